matrix_scan_reader: RTL

- Read-side sequencer for the LED matrix frame buffer; occupies one peripheral port of memory_arbiter.
- Walks a frame row by row and issues byte reads under fifo_full backpressure, with a bounded number of reads in flight.
- Collects returned bytes in order into a ping-pong line buffer.
- Hands each completed row to the row shift-out driver with a valid/consume handshake.

---
 rtl/matrix_scan_reader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_reader.sv
// rtl/matrix_scan_reader.sv - LED matrix frame-buffer read sequencer with ping-pong line buffer (optional MATRIX_SCAN_READER_CONTINUOUS_EN)
module matrix_scan_reader #(
    parameter int ADDRESS_WIDTH   = 25,
    parameter int ROW_BYTES       = 64,
    parameter int ROWS            = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [ADDRESS_WIDTH-1:0]      base_address,
`ifdef MATRIX_SCAN_READER_CONTINUOUS_EN
    input  logic                          continuous,
`endif
    output logic [ADDRESS_WIDTH-1:0]      address,
    output logic                          wr,
    output logic                          data_in_ready,
    input  logic                          fifo_full,
    input  logic [7:0]                    data_out,
    input  logic                          data_out_ready,
    input  logic [$clog2(ROW_BYTES)-1:0]  line_rd_addr,
    output logic [7:0]                    line_rd_data,
    output logic                          line_valid,
    output logic [$clog2(ROWS)-1:0]       line_row,
    input  logic                          line_consume,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int CW = $clog2(ROW_BYTES + 1);
    localparam int LA = $clog2(ROW_BYTES);
    localparam int RW = $clog2(ROWS);
    localparam int unsigned MAXO = MAX_OUTSTANDING;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HANDOFF
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]            req_q, req_d;
    logic [CW-1:0]            rcv_q, rcv_d;
    logic [RW-1:0]            row_q, row_d;
    logic                     wb_q, wb_d;
    logic                     line_valid_q, line_valid_d;
    logic [RW-1:0]            line_row_q, line_row_d;
    logic                     frame_done_q, frame_done_d;
    logic                     issue;
    logic                     accept;
    logic                     cont;
    logic [CW-1:0]            outstanding;
    logic [7:0]               bank_q [2][ROW_BYTES];

`ifdef MATRIX_SCAN_READER_CONTINUOUS_EN
    assign cont = continuous;
`else
    assign cont = 1'b0;
`endif

    // Returns arrive in issue order, so reads in flight is simply issued minus received.
    assign outstanding   = req_q - rcv_q;
    assign address       = addr_q;
    assign wr            = 1'b0;
    assign data_in_ready = issue;
    assign line_valid    = line_valid_q;
    assign line_row      = line_row_q;
    assign frame_done    = frame_done_q;
    assign busy          = (state_q != S_IDLE);
    assign line_rd_data  = bank_q[~wb_q][line_rd_addr];

    // Next-state logic: request issue, return collection, and row handover to the driver.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        req_d        = req_q;
        rcv_d        = rcv_q;
        row_d        = row_q;
        wb_d         = wb_q;
        line_valid_d = line_valid_q;
        line_row_d   = line_row_q;
        frame_done_d = 1'b0;
        issue        = 1'b0;
        accept       = 1'b0;
        // A consume releases the displayed bank; a swap below re-fills it in the same cycle.
        if (line_consume) begin
            line_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    addr_d  = base_address;
                    req_d   = '0;
                    rcv_d   = '0;
                    row_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                issue  = !fifo_full && (32'(outstanding) < MAXO) && (req_q < CW'(ROW_BYTES));
                // Guarding on rcv != req keeps a stray strobe from underflowing the count.
                accept = data_out_ready && (rcv_q != req_q);
                if (issue) begin
                    addr_d = addr_q + ADDRESS_WIDTH'(1);
                    req_d  = req_q + CW'(1);
                end
                if (accept) begin
                    rcv_d = rcv_q + CW'(1);
                end
                if (rcv_d == CW'(ROW_BYTES)) begin
                    state_d = S_HANDOFF;
                end
            end
            S_HANDOFF: begin
                if (!line_valid_q || line_consume) begin
                    wb_d         = ~wb_q;
                    line_valid_d = 1'b1;
                    line_row_d   = row_q;
                    row_d        = row_q + RW'(1);
                    req_d        = '0;
                    rcv_d        = '0;
                    state_d      = S_FETCH;
                    if (row_q == RW'(ROWS - 1)) begin
                        frame_done_d = 1'b1;
                        row_d        = '0;
                        if (cont) begin
                            addr_d = base_address;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers; addr_q is the running row accumulator (base + row offset + req).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            req_q        <= '0;
            rcv_q        <= '0;
            row_q        <= '0;
            wb_q         <= 1'b0;
            line_valid_q <= 1'b0;
            line_row_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            rcv_q        <= rcv_d;
            row_q        <= row_d;
            wb_q         <= wb_d;
            line_valid_q <= line_valid_d;
            line_row_q   <= line_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Ping-pong line storage; returned bytes land in the write bank at the receive index.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_q[wb_q][rcv_q[LA-1:0]] <= data_out;
        end
    end

endmodule
